// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle main decoder.
// Holds the opcode constants, the controller state enum, the memwrite
// access-size encodings and small opcode classification helpers.
`timescale 1ns/1ps
package mc_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpDaddi = 6'b011000;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpLbu   = 6'b100100;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpLd    = 6'b110111;
  localparam logic [5:0] OpSd    = 6'b111111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExec,
    StAluWb,
    StImmExec,
    StBranch,
    StJump,
    StTrap
  } state_e;

  // Doubles as the memwrite output code.
  typedef enum logic [1:0] {
    MwNone  = 2'b00,
    MwWord  = 2'b01,
    MwByte  = 2'b10,
    MwDword = 2'b11
  } mem_size_e;

  function automatic mem_size_e op_size(input logic [5:0] opc);
    case (opc)
      OpLb, OpLbu, OpSb: return MwByte;
      OpLd, OpSd:        return MwDword;
      default:           return MwWord;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] opc);
    return (opc == OpSw) || (opc == OpSb) || (opc == OpSd);
  endfunction

endpackage

// File: rtl/mc_beatctr.sv
// mc_beatctr: memory beat counter with terminal-count compare.
// Ports: clk_i, rst_ni (async active-low), adv_i (beat accepted),
//        clr_i (state exit, wins over adv_i), last_idx_i (final beat index
//        of the active access), beat_o (current index), last_o (beat_o is final).
`timescale 1ns/1ps
module mc_beatctr #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic             clr_i,
  input  logic [Width-1:0] last_idx_i,
  output logic [Width-1:0] beat_o,
  output logic             last_o
);

  logic [Width-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = '0;
    end else if (adv_i) begin
      beat_d = beat_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign beat_o = beat_q;
  assign last_o = (beat_q == last_idx_i);

endmodule

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main decoder / controller for a MIPS-like core with
// a narrow memory bus. Instruction fetch and data accesses are split into
// BUS_W-wide beats; mem_ready low stalls the current beat indefinitely.
// Ports: clk, reset (async active-low), op (IR opcode), mem_ready (beat
//        accepted); outputs mem_req, beat, irwrite, pcwrite, iord, regwrite,
//        memtoreg, regdst, bne, branch, jump, memwrite, alusrc, aluop, illegal.
// Build option: define MC_MAINDEC_DWORD_EN to decode LD/SD/DADDI (needs
//        XLEN=64); otherwise those opcodes trap like any undecoded opcode.
`timescale 1ns/1ps
module mc_maindec
  import mc_pkg::*;
#(
  parameter int unsigned BUS_W = 32,
  parameter int unsigned XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   op,
  input  logic                         mem_ready,
  output logic                         mem_req,
  output logic [$clog2(64/BUS_W)-1:0]  beat,
  output logic                         irwrite,
  output logic                         pcwrite,
  output logic                         iord,
  output logic                         regwrite,
  output logic                         memtoreg,
  output logic                         regdst,
  output logic                         bne,
  output logic                         branch,
  output logic                         jump,
  output logic [1:0]                   memwrite,
  output logic [1:0]                   alusrc,
  output logic [2:0]                   aluop,
  output logic                         illegal
);

  localparam int unsigned BeatW     = $clog2(64 / BUS_W);
  localparam int unsigned ByteBeats = (8 / BUS_W > 1) ? 8 / BUS_W : 1;
  localparam logic [BeatW-1:0] ByteLast  = BeatW'(ByteBeats - 1);
  localparam logic [BeatW-1:0] WordLast  = BeatW'(32 / BUS_W - 1);
  localparam logic [BeatW-1:0] DwordLast = BeatW'(64 / BUS_W - 1);

`ifdef MC_MAINDEC_DWORD_EN
  localparam bit DwordEn = (XLEN == 64);
`else
  // Doubleword ops always trap; XLEN only matters once they are enabled.
  localparam bit DwordEn = 1'b0 && (XLEN == 64);
`endif

  state_e           state_q, state_d;
  logic [BeatW-1:0] last_idx;
  logic             beat_last;
  logic             done;

  // Reset gates the request so no beat can be accepted while held in reset.
  assign mem_req = reset &&
                   ((state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr));
  assign done    = mem_req && mem_ready && beat_last;

  always_comb begin
    last_idx = '0;
    case (state_q)
      StFetch: last_idx = WordLast;
      StMemRd, StMemWr: begin
        case (op_size(op))
          MwByte:  last_idx = ByteLast;
          MwDword: last_idx = DwordLast;
          default: last_idx = WordLast;
        endcase
      end
      default: last_idx = '0;
    endcase
  end

  mc_beatctr #(
    .Width(BeatW)
  ) u_beatctr (
    .clk_i      (clk),
    .rst_ni     (reset),
    .adv_i      (mem_req && mem_ready),
    .clr_i      (state_d != state_q),
    .last_idx_i (last_idx),
    .beat_o     (beat),
    .last_o     (beat_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (done) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLw, OpLb, OpLbu, OpSw, OpSb:    state_d = StMemAdr;
          OpLd, OpSd:                       state_d = DwordEn ? StMemAdr : StTrap;
          OpRtype:                          state_d = StExec;
          OpAddi, OpAndi, OpOri, OpSlti:    state_d = StImmExec;
          OpDaddi:                          state_d = DwordEn ? StImmExec : StTrap;
          OpBeq, OpBne:                     state_d = StBranch;
          OpJ:                              state_d = StJump;
          default:                          state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = op_is_store(op) ? StMemWr : StMemRd;
      StMemRd:  if (done) state_d = StMemWb;
      StMemWr:  if (done) state_d = StFetch;
      StExec, StImmExec: state_d = StAluWb;  // immediate ops share the ALU writeback
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    bne      = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    memwrite = MwNone;
    alusrc   = 2'b00;
    aluop    = 3'b000;
    illegal  = 1'b0;
    case (state_q)
      StFetch: begin
        irwrite = done;
        pcwrite = done;
      end
      StMemAdr: alusrc = 2'b01;
      StMemRd:  iord = 1'b1;
      StMemWr: begin
        iord     = 1'b1;
        memwrite = op_size(op);
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StExec: aluop = 3'b111;
      StAluWb: begin
        regwrite = 1'b1;
        regdst   = (op == OpRtype);
      end
      StImmExec: begin
        alusrc = ((op == OpAddi) || (op == OpDaddi)) ? 2'b01 : 2'b10;
        case (op)
          OpAndi:  aluop = 3'b001;
          OpOri:   aluop = 3'b010;
          OpSlti:  aluop = 3'b011;
          default: aluop = 3'b000;
        endcase
      end
      StBranch: begin
        branch = 1'b1;
        bne    = (op == OpBne);
      end
      StJump: begin
        jump    = 1'b1;
        pcwrite = 1'b1;
      end
      StTrap:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: scoreboard bench for mc_maindec. Three instances cover bus
// widths 8, 16 and 32 (all XLEN=64); each directed step pushes the
// hand-computed output vector for that cycle and a monitor pops and compares.
`timescale 1ns/1ps
module tb_mc_maindec;
  import mc_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic [2:0] beat;
    logic       irwrite, pcwrite, iord, regwrite, memtoreg, regdst, bne, branch, jump;
    logic [1:0] memwrite;
    logic [1:0] alusrc;
    logic [2:0] aluop;
    logic       illegal;
  } out_t;

  typedef struct {
    int    dut;
    out_t  exp;
    string name;
  } chk_t;

  localparam int D8 = 0, D16 = 1, D32 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] op = 6'b0;

  chk_t q[$];
  chk_t cur;
  out_t act;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned BW  = 8 << g;
    localparam int unsigned BEW = $clog2(64 / BW);
    logic           mem_req, irwrite, pcwrite, iord, regwrite, memtoreg, regdst;
    logic           bne, branch, jump, illegal;
    logic [BEW-1:0] beat;
    logic [1:0]     memwrite, alusrc;
    logic [2:0]     aluop;
    out_t           o;

    mc_maindec #(.BUS_W(BW), .XLEN(64)) u_dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .mem_req(mem_req), .beat(beat), .irwrite(irwrite), .pcwrite(pcwrite),
      .iord(iord), .regwrite(regwrite), .memtoreg(memtoreg), .regdst(regdst),
      .bne(bne), .branch(branch), .jump(jump), .memwrite(memwrite),
      .alusrc(alusrc), .aluop(aluop), .illegal(illegal)
    );

    assign o = {mem_req, 3'(beat), irwrite, pcwrite, iord, regwrite, memtoreg, regdst,
                bne, branch, jump, memwrite, alusrc, aluop, illegal};
  end

  // Expected-vector builders; unnamed fields stay zero.
  function automatic out_t o_fetch(input int b, input bit fin);
    out_t r = '0;
    r.mem_req = 1'b1; r.beat = 3'(b); r.irwrite = fin; r.pcwrite = fin;
    return r;
  endfunction
  function automatic out_t o_idle();
    return '0;
  endfunction
  function automatic out_t o_memadr();
    out_t r = '0;
    r.alusrc = 2'b01;
    return r;
  endfunction
  function automatic out_t o_memrd(input int b);
    out_t r = '0;
    r.mem_req = 1'b1; r.iord = 1'b1; r.beat = 3'(b);
    return r;
  endfunction
  function automatic out_t o_memwr(input int b, input logic [1:0] mw);
    out_t r = '0;
    r.mem_req = 1'b1; r.iord = 1'b1; r.beat = 3'(b); r.memwrite = mw;
    return r;
  endfunction
  function automatic out_t o_memwb();
    out_t r = '0;
    r.regwrite = 1'b1; r.memtoreg = 1'b1;
    return r;
  endfunction
  function automatic out_t o_alu(input logic [1:0] src, input logic [2:0] aop);
    out_t r = '0;
    r.alusrc = src; r.aluop = aop;
    return r;
  endfunction
  function automatic out_t o_wb(input bit rd);
    out_t r = '0;
    r.regwrite = 1'b1; r.regdst = rd;
    return r;
  endfunction
  function automatic out_t o_branch(input bit n);
    out_t r = '0;
    r.branch = 1'b1; r.bne = n;
    return r;
  endfunction
  function automatic out_t o_jump();
    out_t r = '0;
    r.jump = 1'b1; r.pcwrite = 1'b1;
    return r;
  endfunction
  function automatic out_t o_trap();
    out_t r = '0;
    r.illegal = 1'b1;
    return r;
  endfunction

  // One cycle: drive inputs just after the rising edge, queue the expectation.
  task automatic step(input int d, input logic rst, input logic [5:0] o, input logic rdy,
                      input out_t e, input string nm);
    chk_t c;
    @(posedge clk);
    #2;
    reset = rst; op = o; mem_ready = rdy;
    c.dut = d; c.exp = e; c.name = nm;
    q.push_back(c);
  endtask

  task automatic do_reset(input int d, input logic [5:0] o);
    step(d, 1'b0, o, 1'b1, o_idle(), "reset_state");
  endtask

  // 32-bit bus: single-beat fetch followed by decode.
  task automatic fetch32(input logic [5:0] o, input string nm);
    step(D32, 1'b1, o, 1'b1, o_fetch(0, 1), {nm, "_fetch"});
    step(D32, 1'b1, o, 1'b1, o_idle(), {nm, "_decode"});
  endtask

  task automatic imm32(input logic [5:0] o, input logic [1:0] src, input logic [2:0] aop,
                       input string nm);
    fetch32(o, nm);
    step(D32, 1'b1, o, 1'b1, o_alu(src, aop), {nm, "_exec"});
    step(D32, 1'b1, o, 1'b1, o_wb(1'b0), {nm, "_wb"});
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      case (cur.dut)
        D8:      act = g_dut[0].o;
        D16:     act = g_dut[1].o;
        default: act = g_dut[2].o;
      endcase
      n_cmp++;
      if (act !== cur.exp) begin
        n_fail++;
        $display("FAIL %s (bus%0d): got %h expected %h", cur.name, 8 << cur.dut, act,
                 cur.exp);
      end
    end
  end

  initial begin
    // R-type on 32-bit bus: FETCH, DECODE, EXEC, ALUWB, FETCH.
    do_reset(D32, OpRtype);
    fetch32(OpRtype, "rt");
    step(D32, 1'b1, OpRtype, 1'b1, o_alu(2'b00, 3'b111), "rt_exec");
    step(D32, 1'b1, OpRtype, 1'b1, o_wb(1'b1), "rt_aluwb");
    step(D32, 1'b1, OpRtype, 1'b1, o_fetch(0, 1), "rt_refetch");

    // LW on 8-bit bus: 4 fetch beats, MEMADR, 4 read beats, MEMWB.
    do_reset(D8, OpLw);
    for (int b = 0; b < 4; b++) step(D8, 1'b1, OpLw, 1'b1, o_fetch(b, b == 3), "lw8_fetch");
    step(D8, 1'b1, OpLw, 1'b1, o_idle(), "lw8_decode");
    step(D8, 1'b1, OpLw, 1'b1, o_memadr(), "lw8_memadr");
    for (int b = 0; b < 4; b++) step(D8, 1'b1, OpLw, 1'b1, o_memrd(b), "lw8_memrd");
    step(D8, 1'b1, OpLw, 1'b1, o_memwb(), "lw8_memwb");
    step(D8, 1'b1, OpLw, 1'b1, o_fetch(0, 0), "lw8_refetch");

    // SB on 16-bit bus with a fetch wait state and 3 store wait states.
    do_reset(D16, OpSb);
    step(D16, 1'b1, OpSb, 1'b0, o_fetch(0, 0), "sb16_fetch_wait");
    step(D16, 1'b1, OpSb, 1'b1, o_fetch(0, 0), "sb16_fetch0");
    step(D16, 1'b1, OpSb, 1'b1, o_fetch(1, 1), "sb16_fetch1");
    step(D16, 1'b1, OpSb, 1'b1, o_idle(), "sb16_decode");
    step(D16, 1'b1, OpSb, 1'b1, o_memadr(), "sb16_memadr");
    for (int i = 0; i < 3; i++) step(D16, 1'b1, OpSb, 1'b0, o_memwr(0, 2'b10), "sb16_wait");
    step(D16, 1'b1, OpSb, 1'b1, o_memwr(0, 2'b10), "sb16_accept");
    step(D16, 1'b1, OpSb, 1'b1, o_fetch(0, 0), "sb16_refetch");

    // LB and SW on 16-bit bus (chained).
    step(D16, 1'b1, OpLb, 1'b1, o_fetch(1, 1), "lb16_fetch1");
    step(D16, 1'b1, OpLb, 1'b1, o_idle(), "lb16_decode");
    step(D16, 1'b1, OpLb, 1'b1, o_memadr(), "lb16_memadr");
    step(D16, 1'b1, OpLb, 1'b1, o_memrd(0), "lb16_memrd");
    step(D16, 1'b1, OpLb, 1'b1, o_memwb(), "lb16_memwb");
    step(D16, 1'b1, OpSw, 1'b1, o_fetch(0, 0), "sw16_fetch0");
    step(D16, 1'b1, OpSw, 1'b1, o_fetch(1, 1), "sw16_fetch1");
    step(D16, 1'b1, OpSw, 1'b1, o_idle(), "sw16_decode");
    step(D16, 1'b1, OpSw, 1'b1, o_memadr(), "sw16_memadr");
    step(D16, 1'b1, OpSw, 1'b1, o_memwr(0, 2'b01), "sw16_beat0");
    step(D16, 1'b1, OpSw, 1'b1, o_memwr(1, 2'b01), "sw16_beat1");
    step(D16, 1'b1, OpSw, 1'b1, o_fetch(0, 0), "sw16_refetch");

    // SD on 32-bit bus: two doubleword beats when enabled, else trap.
    do_reset(D32, OpSd);
    fetch32(OpSd, "sd");
`ifdef MC_MAINDEC_DWORD_EN
    step(D32, 1'b1, OpSd, 1'b1, o_memadr(), "sd_memadr");
    step(D32, 1'b1, OpSd, 1'b1, o_memwr(0, 2'b11), "sd_beat0");
    step(D32, 1'b1, OpSd, 1'b1, o_memwr(1, 2'b11), "sd_beat1");
`else
    step(D32, 1'b1, OpSd, 1'b1, o_trap(), "sd_trap");
`endif
    step(D32, 1'b1, OpSd, 1'b1, o_fetch(0, 1), "sd_refetch");
    step(D32, 1'b1, OpSd, 1'b1, o_idle(), "sd_decode2");

    // Undecoded opcode: one-cycle illegal pulse, no writes.
    do_reset(D32, 6'b111110);
    fetch32(6'b111110, "bad");
    step(D32, 1'b1, 6'b111110, 1'b1, o_trap(), "bad_trap");
    step(D32, 1'b1, 6'b111110, 1'b1, o_fetch(0, 1), "bad_refetch");
    step(D32, 1'b1, 6'b111110, 1'b1, o_idle(), "bad_decode2");
    step(D32, 1'b1, 6'b111110, 1'b1, o_trap(), "bad_trap2");

    // Immediate ops, branches and jump on 32-bit bus.
    imm32(OpAddi, 2'b01, 3'b000, "addi");
    imm32(OpAndi, 2'b10, 3'b001, "andi");
    imm32(OpOri,  2'b10, 3'b010, "ori");
    imm32(OpSlti, 2'b10, 3'b011, "slti");
    fetch32(OpDaddi, "daddi");
`ifdef MC_MAINDEC_DWORD_EN
    step(D32, 1'b1, OpDaddi, 1'b1, o_alu(2'b01, 3'b000), "daddi_exec");
    step(D32, 1'b1, OpDaddi, 1'b1, o_wb(1'b0), "daddi_wb");
`else
    step(D32, 1'b1, OpDaddi, 1'b1, o_trap(), "daddi_trap");
`endif
    fetch32(OpBeq, "beq");
    step(D32, 1'b1, OpBeq, 1'b1, o_branch(1'b0), "beq_branch");
    fetch32(OpBne, "bne");
    step(D32, 1'b1, OpBne, 1'b1, o_branch(1'b1), "bne_branch");
    fetch32(OpJ, "j");
    step(D32, 1'b1, OpJ, 1'b1, o_jump(), "j_jump");
    step(D32, 1'b1, OpJ, 1'b1, o_fetch(0, 1), "j_refetch");

    // Reset during fetch beat 2 of an 8-bit LW: access abandoned, no irwrite.
    do_reset(D8, OpLw);
    step(D8, 1'b1, OpLw, 1'b1, o_fetch(0, 0), "rst8_fetch0");
    step(D8, 1'b1, OpLw, 1'b1, o_fetch(1, 0), "rst8_fetch1");
    step(D8, 1'b0, OpLw, 1'b1, o_idle(), "rst8_abort");
    step(D8, 1'b0, OpLw, 1'b1, o_idle(), "rst8_hold");
    step(D8, 1'b1, OpLw, 1'b1, o_fetch(0, 0), "rst8_restart0");
    step(D8, 1'b1, OpLw, 1'b1, o_fetch(1, 0), "rst8_restart1");

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
